// File: rtl/ha_pkg.sv
// Shared types for the HA_CReg configuration sequencer: FSM states and
// the per-context table entry.
package ha_pkg;

   localparam int CTX_INST_W  = 3;
   localparam int CTX_DWELL_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DWELL = 2'd2
   } seqState_t;

   typedef struct packed {
      logic [CTX_INST_W-1:0]  inst;
      logic [CTX_DWELL_W-1:0] dwell;
   } ctx_entry_t;

   // A dwell of 0 behaves like 1; returns the count loaded in ISSUE.
   function automatic logic [CTX_DWELL_W-1:0] issueCount(input logic [CTX_DWELL_W-1:0] dwell);
      return (dwell == '0) ? '0 : dwell - 1'b1;
   endfunction

endpackage

// File: rtl/ha_ctx_table.sv
// Context register file: NUM_CTX entries, one write port, one
// asynchronous read port, cleared by reset.
module ha_ctx_table
   import ha_pkg::*;
#(
   parameter int NUM_CTX = 4,
   parameter int CTX_AW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wrEn,
   input  logic [CTX_AW-1:0] wrAddr,
   input  ctx_entry_t        wrData,
   input  logic [CTX_AW-1:0] rdAddr,
   output ctx_entry_t        rdData
);

   ctx_entry_t entries [NUM_CTX];

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CTX; i++) begin
         if (rst)
            entries[i] <= '0;
         else if (wrEn && (wrAddr == CTX_AW'(i)))
            entries[i] <= wrData;
      end
   end

   assign rdData = entries[rdAddr];

endmodule

// File: rtl/ha_config_sequencer.sv
// Steps the HA_CReg config input through a table of contexts, issuing a
// one-cycle enable pulse per context and holding it for its dwell count.
module ha_config_sequencer
   import ha_pkg::*;
#(
   parameter int Inst_BW  = CTX_INST_W,
   parameter int NUM_CTX  = 4,
   parameter int CTX_AW   = 2,
   parameter int DWELL_BW = CTX_DWELL_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [CTX_AW-1:0]   cfg_addr,
   input  logic [Inst_BW-1:0]  cfg_inst,
   input  logic [DWELL_BW-1:0] cfg_dwell,
   input  logic                start,
   input  logic [CTX_AW-1:0]   run_last,
   input  logic                stop,
   output logic                busy,
   output logic [CTX_AW-1:0]   ctx_idx,
   output logic                Config_Reg_EN,
   output logic [Inst_BW-1:0]  Config_Reg_InstIn
);

   seqState_t             state;
   logic [CTX_AW-1:0]     runLast;
   logic [CTX_AW-1:0]     ctxIdx;
   logic [CTX_AW-1:0]     nxtIdx;
   logic [DWELL_BW-1:0]   curDwell;
   logic [DWELL_BW-1:0]   cnt;
   logic                  en;
   logic [Inst_BW-1:0]    instIn;
   logic                  wrEn;
   logic                  goIssue;
   ctx_entry_t            wrEntry;
   ctx_entry_t            rdEntry;
   ctx_entry_t            nxtEntry;

   assign cfg_ready = !rst && (state == IDLE);
   assign busy      = !rst && (state != IDLE);
   assign wrEn      = cfg_valid && cfg_ready;

   assign wrEntry.inst  = cfg_inst;
   assign wrEntry.dwell = cfg_dwell;

   // The table is read one context ahead so the outputs can be registered.
   assign nxtIdx = (state == IDLE)      ? '0 :
                   (ctxIdx == runLast)  ? '0 : ctxIdx + 1'b1;

   ha_ctx_table #(
      .NUM_CTX (NUM_CTX),
      .CTX_AW  (CTX_AW)
   ) uTable (
      .clk    (clk),
      .rst    (rst),
      .wrEn   (wrEn),
      .wrAddr (cfg_addr),
      .wrData (wrEntry),
      .rdAddr (nxtIdx),
      .rdData (rdEntry)
   );

   // A write landing with start must reach the first issue, so bypass it.
   assign nxtEntry = (wrEn && (cfg_addr == nxtIdx)) ? wrEntry : rdEntry;

   always_comb begin
      goIssue = 1'b0;
      case (state)
         IDLE:    goIssue = start;
         ISSUE:   goIssue = !stop && (issueCount(curDwell) == '0);
         DWELL:   goIssue = !stop && (cnt == DWELL_BW'(1));
         default: goIssue = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         runLast  <= '0;
         ctxIdx   <= '0;
         curDwell <= '0;
         cnt      <= '0;
         en       <= 1'b0;
         instIn   <= '0;
      end else begin
         en <= 1'b0;
         if (goIssue) begin
            if (state == IDLE)
               runLast <= run_last;
            state    <= ISSUE;
            en       <= 1'b1;
            ctxIdx   <= nxtIdx;
            instIn   <= nxtEntry.inst;
            curDwell <= nxtEntry.dwell;
         end else begin
            case (state)
               ISSUE: begin
                  state <= stop ? IDLE : DWELL;
                  cnt   <= issueCount(curDwell);
               end
               DWELL: begin
                  if (stop)
                     state <= IDLE;
                  else
                     cnt <= cnt - 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign ctx_idx           = ctxIdx;
   assign Config_Reg_EN     = en;
   assign Config_Reg_InstIn = instIn;

endmodule

// File: tb/tb_ha_config_sequencer.sv
// Directed bench for ha_config_sequencer: reset, cyclic sequencing, zero
// dwell, stop, write-with-start, cfg blocking and mid-run reset.
module tb_ha_config_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cfg_valid = 1'b0;
   logic       cfg_ready;
   logic [1:0] cfg_addr = '0;
   logic [2:0] cfg_inst = '0;
   logic [7:0] cfg_dwell = '0;
   logic       start = 1'b0;
   logic [1:0] run_last = '0;
   logic       stop = 1'b0;
   logic       busy;
   logic [1:0] ctx_idx;
   logic       en;
   logic [2:0] instIn;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ha_config_sequencer dut (
      .clk               (clk),
      .rst               (rst),
      .cfg_valid         (cfg_valid),
      .cfg_ready         (cfg_ready),
      .cfg_addr          (cfg_addr),
      .cfg_inst          (cfg_inst),
      .cfg_dwell         (cfg_dwell),
      .start             (start),
      .run_last          (run_last),
      .stop              (stop),
      .busy              (busy),
      .ctx_idx           (ctx_idx),
      .Config_Reg_EN     (en),
      .Config_Reg_InstIn (instIn)
   );

   // After step, outputs show the cycle that just began; inputs set now are
   // sampled at the next edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write(input logic [1:0] a, input logic [2:0] i, input logic [7:0] d);
      cfg_valid = 1'b1; cfg_addr = a; cfg_inst = i; cfg_dwell = d;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++; $display("FAIL write_ready: got %b want 1", cfg_ready);
      end
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic halt();
      stop = 1'b1;
      step();
      stop = 1'b0;
      step();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      checks++;
      if ({en, instIn, busy, cfg_ready, ctx_idx} !== 8'b0) begin
         errors++; $display("FAIL reset_outputs: got en=%b inst=%b busy=%b rdy=%b idx=%0d want all 0",
                            en, instIn, busy, cfg_ready, ctx_idx);
      end
      rst = 1'b0;
      #1;
      checks++;
      if (cfg_ready !== 1'b1) begin
         errors++; $display("FAIL reset_release_ready: got %b want 1", cfg_ready);
      end
   endtask

   task automatic test_sequence();
      logic [2:0] expInst [9];
      logic       expEn   [9];
      expEn   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      expInst = '{3'b000, 3'b101, 3'b101, 3'b101, 3'b010, 3'b101, 3'b101, 3'b101, 3'b010};
      write(2'd0, 3'b101, 8'd3);
      write(2'd1, 3'b010, 8'd1);
      start = 1'b1; run_last = 2'd1;
      for (int k = 1; k <= 8; k++) begin
         step();
         start = 1'b0;
         checks++;
         if (en !== expEn[k] || (expEn[k] && instIn !== expInst[k])) begin
            errors++; $display("FAIL seq_t%0d: got en=%b inst=%b want en=%b inst=%b",
                               k, en, instIn, expEn[k], expInst[k]);
         end
      end
      checks++;
      if (busy !== 1'b1 || ctx_idx !== 2'd1) begin
         errors++; $display("FAIL seq_busy_idx: got busy=%b idx=%0d want 1/1", busy, ctx_idx);
      end
      halt();
   endtask

   task automatic test_zero_dwell();
      write(2'd0, 3'b011, 8'd0);
      start = 1'b1; run_last = 2'd0;
      for (int k = 1; k <= 5; k++) begin
         step();
         start = 1'b0;
         checks++;
         if (en !== 1'b1 || instIn !== 3'b011 || ctx_idx !== 2'd0) begin
            errors++; $display("FAIL zero_dwell_t%0d: got en=%b inst=%b idx=%0d want 1/011/0",
                               k, en, instIn, ctx_idx);
         end
      end
      halt();
      checks++;
      if (busy !== 1'b0) begin
         errors++; $display("FAIL zero_dwell_stop: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_stop();
      int pulses;
      write(2'd0, 3'b101, 8'd3);
      start = 1'b1; run_last = 2'd0;
      step();              // t+1 ISSUE
      start = 1'b0;
      step();              // t+2 first DWELL cycle
      step();              // t+3 second DWELL cycle
      stop = 1'b1;
      step();
      stop = 1'b0;
      checks++;
      if (busy !== 1'b0 || en !== 1'b0 || instIn !== 3'b101 || ctx_idx !== 2'd0) begin
         errors++; $display("FAIL stop_state: got busy=%b en=%b inst=%b idx=%0d want 0/0/101/0",
                            busy, en, instIn, ctx_idx);
      end
      pulses = 0;
      for (int k = 0; k < 6; k++) begin
         step();
         if (en) pulses++;
      end
      checks++;
      if (pulses !== 0 || instIn !== 3'b101) begin
         errors++; $display("FAIL stop_no_pulse: got pulses=%0d inst=%b want 0/101", pulses, instIn);
      end
      start = 1'b1; run_last = 2'd1;
      step();
      start = 1'b0;
      checks++;
      if (en !== 1'b1 || ctx_idx !== 2'd0 || instIn !== 3'b101) begin
         errors++; $display("FAIL restart: got en=%b idx=%0d inst=%b want 1/0/101", en, ctx_idx, instIn);
      end
      repeat (3) step();
      checks++;
      if (en !== 1'b1 || ctx_idx !== 2'd1 || instIn !== 3'b010) begin
         errors++; $display("FAIL restart_ctx1: got en=%b idx=%0d inst=%b want 1/1/010", en, ctx_idx, instIn);
      end
      halt();
   endtask

   task automatic test_write_with_start();
      cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_inst = 3'b111; cfg_dwell = 8'd2;
      start = 1'b1; run_last = 2'd0;
      step();
      cfg_valid = 1'b0; start = 1'b0;
      checks++;
      if (en !== 1'b1 || instIn !== 3'b111) begin
         errors++; $display("FAIL write_start: got en=%b inst=%b want 1/111", en, instIn);
      end
      cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_inst = 3'b000; cfg_dwell = 8'd5;
      #1;
      checks++;
      if (cfg_ready !== 1'b0) begin
         errors++; $display("FAIL run_ready: got %b want 0", cfg_ready);
      end
      step();
      cfg_valid = 1'b0;
      checks++;
      if (en !== 1'b0) begin
         errors++; $display("FAIL run_dwell_gap: got en=%b want 0", en);
      end
      step();
      checks++;
      if (en !== 1'b1 || instIn !== 3'b111) begin
         errors++; $display("FAIL run_table_kept: got en=%b inst=%b want 1/111", en, instIn);
      end
      halt();
   endtask

   task automatic test_reset_mid_dwell();
      start = 1'b1; run_last = 2'd1;
      step();
      start = 1'b0;
      step();              // in DWELL of ctx0 (dwell 2)
      rst = 1'b1;
      step();
      rst = 1'b0;
      #1;
      checks++;
      if ({busy, en, instIn, ctx_idx} !== 7'b0 || cfg_ready !== 1'b1) begin
         errors++; $display("FAIL mid_reset: got busy=%b en=%b inst=%b idx=%0d rdy=%b want 0/0/000/0/1",
                            busy, en, instIn, ctx_idx, cfg_ready);
      end
      start = 1'b1; run_last = 2'd0;
      step();
      start = 1'b0;
      checks++;
      if (en !== 1'b1 || instIn !== 3'b000) begin
         errors++; $display("FAIL cleared_table: got en=%b inst=%b want 1/000", en, instIn);
      end
      step();
      checks++;
      if (en !== 1'b1) begin
         errors++; $display("FAIL cleared_dwell: got en=%b want 1", en);
      end
      halt();
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_zero_dwell();
      test_stop();
      test_write_with_start();
      test_reset_mid_dwell();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
